// File: rtl/iter_barrel_shifter.sv
// ---------------------------------------------------------------------------
// iter_barrel_shifter
//
// Multi-cycle barrel shifter/rotator. It works through one log2 stage per
// clock and reuses a single stage datapath instead of building a full mux
// tree. An accepted operation takes SHW cycles in BUSY. The result is then
// held in DONE until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers an operation (din/shamt/lr/al/rot)
//   in_ready   block is IDLE and can accept an operation
//   din        WIDTH-bit operand
//   shamt      shift amount, 0..WIDTH-1 (unsigned)
//   lr         1 = left, 0 = right
//   al         right shifts only: 1 = arithmetic, 0 = logical
//   rot        1 = rotate in direction lr (al ignored)
//   out_valid  dout holds a finished result
//   out_ready  consumer accepts dout
//   dout       result; stays stable while out_valid && !out_ready
//   busy       high while an operation is in flight or waiting in DONE
// ---------------------------------------------------------------------------
module iter_barrel_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           din,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic                       lr,
    input  logic                       al,
    input  logic                       rot,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dout,
    output logic                       busy
);

    localparam int SHW    = $clog2(WIDTH);
    localparam int LAST_I = SHW - 1;
    localparam int ONE_I  = 1;
    localparam logic [SHW-1:0] LAST_STAGE = LAST_I[SHW-1:0];
    localparam logic [SHW-1:0] STAGE_ONE  = ONE_I[SHW-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    // stage_q only needs log2(SHW) bits. SHW bits is always enough and
    // still works when SHW = 1.
    logic [SHW-1:0]   stage_q, stage_d;
    logic [SHW-1:0]   shamt_q, shamt_d;
    logic             lr_q, lr_d;
    logic             al_q, al_d;
    logic             rot_q, rot_d;

    // For each stage, the accumulator shifted by 2^gi in the captured mode.
    // Only the entry for the current stage is used in any cycle.
    logic [WIDTH-1:0] cand [SHW];
    logic [WIDTH-1:0] shifted;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int K = 1 << gi;   // K <= WIDTH/2, so all slices are valid
            logic [WIDTH-1:0] shl, lsr, asr, rol, ror;
            assign shl = acc_q << K;
            assign lsr = acc_q >> K;
            // The MSB of acc never changes during an arithmetic right shift,
            // so it is always the original sign bit.
            assign asr = {{K{acc_q[WIDTH-1]}}, acc_q[WIDTH-1:K]};
            assign rol = {acc_q[WIDTH-1-K:0], acc_q[WIDTH-1:WIDTH-K]};
            assign ror = {acc_q[K-1:0], acc_q[WIDTH-1:K]};
            assign cand[gi] = rot_q ? (lr_q ? rol : ror)
                            : lr_q  ? shl
                            : al_q  ? asr
                            :         lsr;
        end
    endgenerate

    // Select the stage candidate, or hold when this bit of shamt is clear.
    always_comb begin
        shifted = acc_q;
        for (int i = 0; i < SHW; i++) begin
            if ((stage_q == i[SHW-1:0]) && shamt_q[i]) begin
                shifted = cand[i];
            end
        end
    end

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            stage_q <= '0;
            shamt_q <= '0;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stage_q <= stage_d;
            shamt_q <= shamt_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
            rot_q   <= rot_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        stage_d = stage_q;
        shamt_d = shamt_q;
        lr_d    = lr_q;
        al_d    = al_q;
        rot_d   = rot_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = din;
                    shamt_d = shamt;
                    lr_d    = lr;
                    al_d    = al;
                    rot_d   = rot;
                    stage_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = shifted;
                if (stage_q == LAST_STAGE) begin
                    stage_d = '0;
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + STAGE_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs. dout shows acc directly. acc only changes in BUSY or on an
    // accept, so it holds through DONE and after the return to IDLE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY) || (state_q == DONE);
        dout      = acc_q;
    end

endmodule

// File: doc/iter_barrel_shifter.md
Name: iter_barrel_shifter

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational shifter (din/shamt/LR/AL).
- Generalised to WIDTH bits; adds rotate mode.
- Processes one log2 shift stage per clock, using a single shared stage datapath instead of a full mux tree.
- Sits between a producer and a consumer via valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, data width; power of two, >= 2.
- SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an operation on din/shamt/lr/al/rot.
- in_ready  output  1  block can accept an operation.
- din  input  WIDTH  operand.
- shamt  input  SHW  shift amount, 0..WIDTH-1.
- lr  input  1  direction: 1 = left, 0 = right.
- al  input  1  right shifts only: 1 = arithmetic (sign fill), 0 = logical (zero fill).
- rot  input  1  1 = rotate in direction lr; overrides al.
- out_valid  output  1  dout holds a finished result.
- out_ready  input  1  consumer accepts dout.
- dout  output  WIDTH  result.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0; dout = 0.
  - Internal accumulator, stage counter and captured controls clear to 0.
  - Reset mid-operation aborts the operation; no result is ever presented for it.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at a clock edge: capture din into acc; capture shamt, lr, al, rot; stage = 0; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle: if shamt_q[stage] = 1, acc shifts by 2^stage per the mode; else acc holds.
  - stage increments each cycle.
  - When stage = SHW-1, this cycle's result goes into acc and the state moves to DONE.
- DONE:
  - out_valid = 1; dout = acc.
  - dout must stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE; out_valid falls; dout keeps its last value.
  - in_ready rises in the following cycle. There is no same-cycle accept/return overlap.
- Latency and throughput:
  - Fixed latency, independent of shamt: out_valid is high from the SHW-th rising edge after the accept edge (WIDTH=8: 3 edges).
  - Throughput: one operation per SHW+2 cycles when out_ready is held high.
- Shift rules per stage (amount k = 2^stage):
  - Left shift: zero fill from the LSB. al is ignored.
  - Logical right: zero fill from the MSB.
  - Arithmetic right: fill with acc[WIDTH-1]. This equals the original sign bit, which is preserved across stages.
  - Rotate: bits shifted out re-enter at the opposite end. al is ignored.
- Boundaries:
  - shamt = 0: dout = din after the full latency.
  - shamt = WIDTH-1 arithmetic right: dout is all copies of din[WIDTH-1].
  - Inputs are ignored whenever in_ready = 0. Changing din or the controls during BUSY has no effect.
  - in_valid held high across a DONE->IDLE return: accepted exactly once per IDLE cycle.
- Width: all arithmetic stays within WIDTH bits. Shift amounts are unsigned.

Test Plan:
1. WIDTH=8; din=0x96, shamt=3, lr=0, al=1, rot=0 -> dout=0xF2, out_valid 3 edges after accept. Same with al=0 -> 0x12.
2. WIDTH=8; din=0x96, shamt=3, lr=1 -> 0xB0. With rot=1, lr=1 -> 0xB4. With rot=1, lr=0 -> 0xD2. With rot=1 and al=1, result is unchanged.
3. WIDTH=8; din=0x80, shamt=7, lr=0, al=1 -> 0xFF. din=0x5A, shamt=0 -> 0x5A, still after 3-edge latency.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and dout stable, in_ready=0. Then raise out_ready for 1 cycle -> IDLE, and in_ready=1 on the next cycle.
5. Reset mid-BUSY: assert rst_n=0 asynchronously at stage 1 -> outputs go immediately to reset values. After release, a new operation (0x01, shamt=1, lr=1) yields 0x02 with no stale result.
6. WIDTH=32; din=0x8000_0001, shamt=31, lr=0, al=1 -> 0xFFFF_FFFF, latency 5. Same with rot=1, lr=1 -> 0xC000_0000. Also a random sweep against a reference model.
